// File: rtl/es8psk_pkg.sv
// Shared es8psk transmitter definitions: FIR geometry and sequencer state type.
package es8psk_pkg;

  localparam int unsigned FIR_TAPS = 46;
  localparam int unsigned FIR_LAT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tag_pipe.sv
// Shift pipe carrying {valid, last} tags alongside the FIR data path.
module tag_pipe #(
  parameter int unsigned Depth = 9
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o,
  output logic any_valid_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] last_q, last_d;

  // Shift one stage per clock; new tag enters at stage 0.
  always_comb begin
    valid_d    = valid_q << 1;
    last_d     = last_q << 1;
    valid_d[0] = valid_i;
    last_d[0]  = last_i;
  end

  // Tag registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o     = valid_q[Depth-1];
  assign last_o      = last_q[Depth-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/fir_45_seq.sv
// Burst sequencer for fir_45: zero-stuffs gaps, flushes the tail, re-frames the output.
module fir_45_seq #(
  parameter int unsigned W       = 20,
  parameter int unsigned TAPS    = es8psk_pkg::FIR_TAPS,
  parameter int unsigned FIR_LAT = es8psk_pkg::FIR_LAT,
  parameter int unsigned GAP_MAX = 64
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [W-1:0] fir_din,
  input  logic [W-1:0] fir_dout,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  output logic         err_gap,
  output logic         busy
);

  import es8psk_pkg::*;

  localparam int unsigned GW = $clog2(GAP_MAX + 1);
  localparam int unsigned FW = $clog2(TAPS);
  localparam logic [GW-1:0] GapMax   = GW'(GAP_MAX);
  localparam logic [FW-1:0] FlushLen = FW'(TAPS - 1);

  seq_state_t    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [W-1:0]  din_q, din_d;
  logic          err_q, err_d;
  logic [W-1:0]  m_data_q;
  logic          m_valid_q, m_last_q;
  logic          hs, tag_valid, tag_last;
  logic          pipe_valid, pipe_last, pipe_any;

  assign s_ready = (state_q != FLUSH);
  assign hs      = s_valid && s_ready;

  // Next-state, counters and the tags for the sample entering fir_din this edge.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    flush_d  = flush_q;
    err_d    = 1'b0;
    tag_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          gap_d = '0;
          if (s_last) begin
            state_d = FLUSH;
            flush_d = FlushLen;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (hs) begin
          gap_d = '0;
          if (s_last) begin
            state_d = FLUSH;
            flush_d = FlushLen;
          end
        end else begin
          // Idle cycle is still a (zero) sample; too many in a row ends the burst.
          gap_d = gap_q + GW'(1);
          if (gap_d == GapMax) begin
            state_d = FLUSH;
            flush_d = FlushLen;
            err_d   = 1'b1;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q - FW'(1);
        if (flush_q == FW'(1)) begin
          tag_last = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Valid while in a burst, including the edge that leaves FLUSH.
    tag_valid = (state_d != IDLE) || (state_q != IDLE);
    din_d     = hs ? s_data : '0;
  end

  // State, counters, FIR input and output framing registers.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      flush_q   <= '0;
      din_q     <= '0;
      err_q     <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      flush_q   <= flush_d;
      din_q     <= din_d;
      err_q     <= err_d;
      m_data_q  <= fir_dout;
      m_valid_q <= pipe_valid;
      m_last_q  <= pipe_last;
    end
  end

  // Stage 0 lines up with fir_din; the last stage lines up with fir_dout.
  tag_pipe #(
    .Depth(FIR_LAT + 1)
  ) u_tag_pipe (
    .clk_i      (clk),
    .rst_ni     (reset_b),
    .valid_i    (tag_valid),
    .last_i     (tag_last),
    .valid_o    (pipe_valid),
    .last_o     (pipe_last),
    .any_valid_o(pipe_any)
  );

  assign fir_din = din_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign err_gap = err_q;
  assign busy    = (state_q != IDLE) || pipe_any || m_valid_q;

endmodule
